// File: rtl/nibbler_fetch_seq.sv
// Nibbler fetch/sequencing front end: PC, two-phase toggle, instruction/operand latch and C/Z flags.
// Optional halt support is compiled in when NIBBLER_FETCH_HALT_EN is defined.
module nibbler_fetch_seq #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  romData,
  input  logic        incPC,
  input  logic        notLoadPC,
  input  logic        notLoadFlags,
  input  logic        carryIn,
  input  logic        zeroIn,
  input  logic        halt,
  output logic [11:0] romAddr,
  output logic [3:0]  instruction,
  output logic [3:0]  operand,
  output logic [11:0] targetAddr,
  output logic        phaseOut,
  output logic [1:0]  flagsOut,
  output logic        halted
);

  logic [11:0] pc;
  logic        phase;
  logic        running;

`ifdef NIBBLER_FETCH_HALT_EN
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, nextState;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= nextState;
  end

  // Halt is only honoured on the execute edge so the current instruction completes.
  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (phase && halt) nextState = HALTED;
      HALTED:  if (!halt)         nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  assign running = (state == RUN);
  assign halted  = (state == HALTED);
`else
  logic unusedHalt;
  assign unusedHalt = halt;
  assign running    = 1'b1;
  assign halted     = 1'b0;
`endif

  assign targetAddr = {operand, romData};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      phase       <= 1'b0;
      instruction <= 4'h0;
      operand     <= 4'h0;
      flagsOut    <= 2'b11;
    end else if (running) begin
      phase <= ~phase;
      if (!phase) {instruction, operand} <= romData;
      // Jump load wins over increment; PC wraps naturally at 12 bits.
      if (!notLoadPC)  pc <= targetAddr;
      else if (incPC)  pc <= pc + 12'd1;
      if (phase && !notLoadFlags) flagsOut <= {~carryIn, ~zeroIn};
    end
  end

  assign romAddr  = pc;
  assign phaseOut = phase;

endmodule

// File: tb/tb_nibbler_fetch_seq.sv
// Directed self-checking bench for nibbler_fetch_seq; halt section follows NIBBLER_FETCH_HALT_EN.
module tb_nibbler_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  romData;
  logic        incPC, notLoadPC, notLoadFlags, carryIn, zeroIn, halt;
  logic [11:0] romAddr, targetAddr;
  logic [3:0]  instruction, operand;
  logic        phaseOut, halted;
  logic [1:0]  flagsOut;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibbler_fetch_seq dut (
    .clk(clk), .reset(reset), .romData(romData), .incPC(incPC),
    .notLoadPC(notLoadPC), .notLoadFlags(notLoadFlags), .carryIn(carryIn),
    .zeroIn(zeroIn), .halt(halt), .romAddr(romAddr), .instruction(instruction),
    .operand(operand), .targetAddr(targetAddr), .phaseOut(phaseOut),
    .flagsOut(flagsOut), .halted(halted)
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; romData = 8'h00; incPC = 1'b0; notLoadPC = 1'b1;
    notLoadFlags = 1'b1; carryIn = 1'b0; zeroIn = 1'b0; halt = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_pc", romAddr, 12'h000);
    check("rst_phase", {11'd0, phaseOut}, 12'h000);
    check("rst_instr", {8'd0, instruction}, 12'h000);
    check("rst_operand", {8'd0, operand}, 12'h000);
    check("rst_flags", {10'd0, flagsOut}, 12'h003);
    check("rst_halted", {11'd0, halted}, 12'h000);

    // Sequential fetch with increment every cycle.
    romData = 8'h4A; incPC = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_pc", romAddr, 12'(i));
      check("seq_phase", {11'd0, phaseOut}, 12'(i % 2));
    end
    check("seq_instr", {8'd0, instruction}, 12'h004);
    check("seq_operand", {8'd0, operand}, 12'h00A);

    // Load beats increment.
    romData = 8'h63; incPC = 1'b0;
    step();
    check("ld_hold_pc", romAddr, 12'h004);
    check("ld_operand", {8'd0, operand}, 12'h003);
    romData = 8'hC5; notLoadPC = 1'b0; incPC = 1'b1;
    #1 check("ld_target", targetAddr, 12'h3C5);
    step();
    check("ld_pc", romAddr, 12'h3C5);
    check("ld_phase", {11'd0, phaseOut}, 12'h000);

    // Jump to FFF, then wrap.
    romData = 8'h0F; notLoadPC = 1'b1; incPC = 1'b0;
    step();
    romData = 8'hFF; notLoadPC = 1'b0;
    step();
    check("jmp_fff", romAddr, 12'hFFF);
    notLoadPC = 1'b1; incPC = 1'b1;
    step();
    check("wrap_pc", romAddr, 12'h000);

    // Flags capture in execute phase, ignored in fetch phase.
    incPC = 1'b0; notLoadFlags = 1'b0; carryIn = 1'b1; zeroIn = 1'b0;
    step();
    check("flags_ph1", {10'd0, flagsOut}, 12'h001);
    carryIn = 1'b0;
    step();
    check("flags_ph0", {10'd0, flagsOut}, 12'h001);
    notLoadFlags = 1'b1;
    step();
    check("pre_jmp_phase", {11'd0, phaseOut}, 12'h000);

    // Jump to 010.
    romData = 8'h00;
    step();
    romData = 8'h10; notLoadPC = 1'b0;
    step();
    notLoadPC = 1'b1;
    check("jmp_010", romAddr, 12'h010);

`ifdef NIBBLER_FETCH_HALT_EN
    halt = 1'b1;
    step();
    check("halt_ph0_ignored", {11'd0, halted}, 12'h000);
    step();
    check("halt_enter", {11'd0, halted}, 12'h001);
    check("halt_pc", romAddr, 12'h010);
    romData = 8'h77; incPC = 1'b1; notLoadPC = 1'b0;
    notLoadFlags = 1'b0; carryIn = 1'b0; zeroIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frz_pc", romAddr, 12'h010);
      check("frz_halted", {11'd0, halted}, 12'h001);
      check("frz_phase", {11'd0, phaseOut}, 12'h000);
    end
    check("frz_flags", {10'd0, flagsOut}, 12'h001);
    halt = 1'b0; notLoadPC = 1'b1; notLoadFlags = 1'b1; romData = 8'h00;
    step();
    check("release_halted", {11'd0, halted}, 12'h000);
    check("release_pc", romAddr, 12'h010);
    step();
    check("resume_pc", romAddr, 12'h011);
    romData = 8'hF0; notLoadPC = 1'b0; notLoadFlags = 1'b0;
    carryIn = 1'b1; zeroIn = 1'b1; halt = 1'b1;
    step();
    check("h2_pc", romAddr, 12'h0F0);
    check("h2_flags", {10'd0, flagsOut}, 12'h000);
    check("h2_halted", {11'd0, halted}, 12'h001);
`else
    halt = 1'b1; incPC = 1'b1;
    step();
    check("nohalt_pc1", romAddr, 12'h011);
    check("nohalt_halted1", {11'd0, halted}, 12'h000);
    step();
    check("nohalt_pc2", romAddr, 12'h012);
    check("nohalt_halted2", {11'd0, halted}, 12'h000);
    romData = 8'h00; incPC = 1'b0;
    step();
    romData = 8'hF0; notLoadPC = 1'b0; notLoadFlags = 1'b0;
    carryIn = 1'b1; zeroIn = 1'b1;
    step();
    check("pre_rst_pc", romAddr, 12'h0F0);
    check("pre_rst_flags", {10'd0, flagsOut}, 12'h000);
    notLoadPC = 1'b1; notLoadFlags = 1'b1; romData = 8'h5B;
    step();
    check("mid_instr", {8'd0, instruction}, 12'h005);
`endif

    // Reset dominates whatever state the block is in.
    reset = 1'b1; incPC = 1'b1;
    step();
    check("rst2_pc", romAddr, 12'h000);
    check("rst2_flags", {10'd0, flagsOut}, 12'h003);
    check("rst2_halted", {11'd0, halted}, 12'h000);
    check("rst2_phase", {11'd0, phaseOut}, 12'h000);
    check("rst2_instr", {8'd0, instruction}, 12'h000);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibbler_fetch_seq.md
# nibbler_fetch_seq

Fetch/sequencing front end of the Nibbler control path: holds the 12-bit program counter, the two-phase clock-phase toggle, the fetched instruction/operand register and the C/Z flags register. It drives `instruction`, `phaseOut` and `flagsOut` into the microcode ROM and consumes that ROM's `incPC`, `notLoadPC` and `notLoadFlags` strobes on the following edge. It also produces the program-ROM address and the 12-bit jump/RAM address.

## Interface
- `PC_RESET`, default 12'h000, PC value loaded by reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `romData`  in  8  program ROM byte at `romAddr`.
- `incPC`  in  1  from microcode: increment PC this cycle.
- `notLoadPC`  in  1  from microcode, active-low: load PC with jump target.
- `notLoadFlags`  in  1  from microcode, active-low: capture ALU flags.
- `carryIn`  in  1  ALU carry-out.
- `zeroIn`  in  1  ALU zero result.
- `halt`  in  1  halt request (see Configuration).
- `romAddr`  out  12  equals PC.
- `instruction`  out  4  latched opcode nibble.
- `operand`  out  4  latched operand nibble (immediate / address high nibble).
- `targetAddr`  out  12  combinational {operand, romData}; jump target and RAM address.
- `phaseOut`  out  1  0 = fetch, 1 = execute.
- `flagsOut`  out  2  [1] = notCarry, [0] = notZero (stored inverted).
- `halted`  out  1  sequencer frozen.

## Operation
- Reset: PC=`PC_RESET`, phase=0, instruction=4'h0, operand=4'h0, flagsOut=2'b11, halted=0, state RUN.
- Phase toggles every edge in RUN: 0,1,0,1…
- Phase 0 edge: {instruction, operand} <= romData.
- Any edge in RUN: if `notLoadPC`=0 then PC <= targetAddr; else if `incPC`=1 then PC <= PC+1; else hold. Load has priority over increment when both asserted.
- PC arithmetic mod 2^12: 12'hFFF + 1 -> 12'h000, no flag.
- Flags: on an edge with phase=1 and `notLoadFlags`=0, flagsOut <= {~carryIn, ~zeroIn}. `notLoadFlags`=0 during phase 0 is ignored.
- `targetAddr` is purely combinational; valid in phase 1 when `romData` holds the second byte.
- States: RUN, HALTED. RUN->HALTED on a phase-1 edge with `halt`=1 (instruction completes normally on that edge). HALTED->RUN on any edge with `halt`=0. In HALTED: phase held at 0, PC, instruction/operand, flags frozen; `incPC`/`notLoadPC`/`notLoadFlags` ignored; halted=1.
- `halt` sampled during phase 0 has no effect until the next phase-1 edge.

## Timing
- All outputs registered except `targetAddr`, `romAddr` (= PC register).
- Opcode visible on `instruction` one cycle after its byte is on `romData`; phaseOut=1 in that same cycle.
- Microcode strobes are combinational from this block's outputs; their effect lands on the next edge (one-cycle loop, no extra latency).
- One instruction = 2 cycles; jump target PC visible the cycle after the phase-1 edge.
- Reset dominates everything on the same edge, including in HALTED; mid-instruction reset discards the instruction.
- `halted` rises the cycle after the qualifying phase-1 edge; first fetch after release occurs one cycle after `halt` drops.

## Configuration
- `NIBBLER_FETCH_HALT_EN` defined: HALTED state and `halt` handling compiled in as above.
- Not defined: `halt` ignored, state machine removed, `halted` tied 0, block always in RUN.

## Test plan
- Reset then 4 cycles with incPC=1 every cycle, romData=8'h4A: romAddr 000,001,002,003,004; phaseOut 0,1,0,1; instruction=4'h4, operand=4'hA.
- Phase 1 with operand=4'h3, romData=8'hC5, notLoadPC=0, incPC=1: next PC=12'h3C5 (load beats increment).
- PC=12'hFFF, incPC=1, notLoadPC=1: next PC=12'h000.
- Phase 1, notLoadFlags=0, carryIn=1, zeroIn=0: flagsOut=2'b01; same strobe in phase 0 with carryIn=0: flagsOut unchanged.
- With macro: halt=1 in phase 1 at PC=12'h010 -> halted=1, phaseOut=0, PC stays 12'h010 for 5 cycles despite incPC=1; halt=0 -> resumes, PC 010->011; without macro halted stays 0.
- Assert reset during HALTED at PC=12'h0F0, flags 2'b00: next cycle PC=12'h000, flagsOut=2'b11, halted=0, phaseOut=0.
